// File: rtl/game_pkg.sv
// Shared definitions for the top-level game FSM and the round timer.
package game_pkg;

    typedef enum logic [1:0] {
        MainIdle  = 2'b00,
        MainMenu  = 2'b01,
        MainGame  = 2'b10,
        MainScore = 2'b11
    } main_state_e;

    localparam logic [1:0] GAME_CODE_DEF = MainGame;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused,
        StExpired
    } timer_state_e;

    localparam int unsigned MS_PER_SEC = 1000;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts 0..DIV-1 while enabled and pulses tick on the wrap cycle.
module tick_prescaler #(
    parameter int unsigned DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_round_timer.sv
// Round countdown timer for the GAME state, with pause, bonus time and a one-cycle expiry pulse.
// Optional low-time warning output enabled by defining GAME_ROUND_TIMER_WARN_EN.
module game_round_timer
    import game_pkg::*;
#(
    parameter int unsigned         CLK_HZ    = 100_000_000,
    parameter int unsigned         SEC_W     = 8,
    parameter int unsigned         STATE_W   = 2,
    parameter logic [STATE_W-1:0]  GAME_CODE = STATE_W'(GAME_CODE_DEF),
    parameter int unsigned         WARN_SEC  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STATE_W-1:0] state_in,
    input  logic [SEC_W-1:0]   time_in,
    input  logic               pause,
    input  logic               add_valid,
    input  logic [SEC_W-1:0]   add_sec,
    output logic               end_of_time,
    output logic               running,
    output logic [SEC_W-1:0]   sec_left,
    output logic [9:0]         ms_left,
    output logic               warn
);

    localparam int unsigned      DIV     = CLK_HZ / MS_PER_SEC;
    localparam logic [9:0]       MS_MAX  = 10'(MS_PER_SEC - 1);
    localparam logic [SEC_W-1:0] SEC_SAT = '1;

    timer_state_e     state_q, state_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [9:0]       ms_q, ms_d;
    logic             eot_q, eot_d;
    logic             running_q, running_d;
    logic             warn_q, warn_d;

    logic             in_game, active, presc_en, presc_clr, tick, expire;
    logic [SEC_W-1:0] sec_dec;
    logic [9:0]       ms_dec;
    logic [SEC_W:0]   sec_sum;

    assign in_game   = (state_in == GAME_CODE);
    assign active    = (state_q == StRun) || (state_q == StPaused);
    // The resume cycle counts, so a pause delays expiry by exactly its length.
    assign presc_en  = in_game && active && !pause;
    assign presc_clr = !in_game || (state_q == StIdle);

    tick_prescaler #(
        .DIV (DIV)
    ) u_tick_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en),
        .clr  (presc_clr),
        .tick (tick)
    );

    always_comb begin
        sec_dec = sec_q;
        ms_dec  = ms_q;
        expire  = 1'b0;
        if (tick) begin
            if (ms_q == '0 && sec_q != '0) begin
                sec_dec = sec_q - 1'b1;
                ms_dec  = MS_MAX;
            end else begin
                ms_dec = ms_q - 1'b1;
            end
            expire = (sec_q == '0) && (ms_q == 10'd1);
        end
        sec_sum = {1'b0, sec_dec} + {1'b0, add_sec};
    end

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        ms_d    = ms_q;
        eot_d   = 1'b0;
        if (!in_game) begin
            state_d = StIdle;
            sec_d   = '0;
            ms_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    sec_d = time_in;
                    ms_d  = '0;
                    if (time_in == '0) begin
                        state_d = StExpired;
                        eot_d   = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
                StRun, StPaused: begin
                    state_d = pause ? StPaused : StRun;
                    sec_d   = sec_dec;
                    ms_d    = ms_dec;
                    if (add_valid) begin
                        sec_d = sec_sum[SEC_W] ? SEC_SAT : sec_sum[SEC_W-1:0];
                    end
                    if (expire) begin
                        // A nonzero bonus on the final tick restarts from add_sec-1 s 999 ms.
                        if (add_valid && add_sec != '0) begin
                            sec_d = add_sec - 1'b1;
                            ms_d  = MS_MAX;
                        end else begin
                            state_d = StExpired;
                            eot_d   = 1'b1;
                            sec_d   = '0;
                            ms_d    = '0;
                        end
                    end
                end
                StExpired: begin
                end
            endcase
        end
        running_d = (state_d == StRun);
    end

`ifdef GAME_ROUND_TIMER_WARN_EN
    assign warn_d = ((state_d == StRun) || (state_d == StPaused)) &&
                    (sec_d < SEC_W'(WARN_SEC));
`else
    logic unused_warn_sec;
    assign unused_warn_sec = ^WARN_SEC;
    assign warn_d          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            sec_q     <= '0;
            ms_q      <= '0;
            eot_q     <= 1'b0;
            running_q <= 1'b0;
            warn_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            ms_q      <= ms_d;
            eot_q     <= eot_d;
            running_q <= running_d;
            warn_q    <= warn_d;
        end
    end

    assign end_of_time = eot_q;
    assign running     = running_q;
    assign sec_left    = sec_q;
    assign ms_left     = ms_q;
    assign warn        = warn_q;

endmodule

// File: tb/tb_game_round_timer.sv
// Scoreboard bench for game_round_timer: a millisecond-level model predicts every cycle's outputs.
module tb_game_round_timer;

    localparam int unsigned CLK_HZ   = 10_000;
    localparam int unsigned DIV      = CLK_HZ / 1000;
    localparam int unsigned WARN_SEC = 5;
    localparam int          SEC_MAX  = 255;
    localparam logic [1:0]  MENU     = 2'b01;
    localparam logic [1:0]  GAME     = 2'b10;
    localparam logic [1:0]  SCORE    = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state_in;
    logic [7:0] time_in;
    logic       pause;
    logic       add_valid;
    logic [7:0] add_sec;
    logic       end_of_time;
    logic       running;
    logic [7:0] sec_left;
    logic [9:0] ms_left;
    logic       warn;

    always #5 clk = ~clk;

    game_round_timer #(
        .CLK_HZ    (CLK_HZ),
        .SEC_W     (8),
        .STATE_W   (2),
        .GAME_CODE (2'b10),
        .WARN_SEC  (WARN_SEC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .state_in    (state_in),
        .time_in     (time_in),
        .pause       (pause),
        .add_valid   (add_valid),
        .add_sec     (add_sec),
        .end_of_time (end_of_time),
        .running     (running),
        .sec_left    (sec_left),
        .ms_left     (ms_left),
        .warn        (warn)
    );

    typedef struct packed {
        logic       eot;
        logic       run;
        logic [7:0] sec;
        logic [9:0] ms;
        logic       warn;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: remaining time kept as a total count of milliseconds.
    typedef enum {MIdle, MActive, MExpired} mmode_e;
    mmode_e m_mode = MIdle;
    int     m_rem  = 0;
    int     m_ph   = 0;

    task automatic model_step(input logic r, input logic [1:0] s, input int t, input logic p,
                              input logic av, input int as);
        exp_t e;
        logic eot = 1'b0;
        logic run = 1'b0;
        bit   tk  = 1'b0;
        int   sec;
        if (r || s != GAME) begin
            m_mode = MIdle;
            m_rem  = 0;
            m_ph   = 0;
        end else begin
            case (m_mode)
                MIdle: begin
                    m_ph = 0;
                    if (t == 0) begin
                        m_mode = MExpired;
                        m_rem  = 0;
                        eot    = 1'b1;
                    end else begin
                        m_mode = MActive;
                        m_rem  = t * 1000;
                        run    = 1'b1;
                    end
                end
                MActive: begin
                    if (!p) begin
                        m_ph++;
                        if (m_ph == DIV) begin
                            m_ph = 0;
                            tk   = 1'b1;
                        end
                    end
                    if (tk) m_rem--;
                    if (av) begin
                        if (tk && m_rem == 0) begin
                            if (as != 0) m_rem = as * 1000 - 1;
                        end else begin
                            sec = m_rem / 1000 + as;
                            if (sec > SEC_MAX) sec = SEC_MAX;
                            m_rem = sec * 1000 + m_rem % 1000;
                        end
                    end
                    if (m_rem == 0) begin
                        m_mode = MExpired;
                        eot    = 1'b1;
                    end else begin
                        run = !p;
                    end
                end
                default: begin
                end
            endcase
        end
        e.eot = eot;
        e.run = run;
        e.sec = 8'(m_rem / 1000);
        e.ms  = 10'(m_rem % 1000);
`ifdef GAME_ROUND_TIMER_WARN_EN
        e.warn = (m_mode == MActive) && ((m_rem / 1000) < WARN_SEC);
`else
        e.warn = 1'b0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic [1:0] s, input logic [7:0] t, input logic p,
                       input logic av, input logic [7:0] as);
        rst       = r;
        state_in  = s;
        time_in   = t;
        pause     = p;
        add_valid = av;
        add_sec   = as;
        model_step(r, s, int'(t), p, av, int'(as));
        @(negedge clk);
    endtask

    // Monitor: one expected record per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {end_of_time, running, sec_left, ms_left, warn};
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL outputs @%0t: got eot=%b run=%b sec=%0d ms=%0d warn=%b, want eot=%b run=%b sec=%0d ms=%0d warn=%b",
                             $time, got.eot, got.run, got.sec, got.ms, got.warn,
                             e.eot, e.run, e.sec, e.ms, e.warn);
                end
            end
        end
    end

    initial begin
        logic p;
        p = 1'b0;
        // Reset and idle
        repeat (3) cyc(1'b1, MENU, 8'd0, 1'b0, 1'b0, 8'd0);
        repeat (2) cyc(1'b0, MENU, 8'd2, 1'b0, 1'b0, 8'd0);

        // Plain 2 s round, mid-round time_in noise, adds ignored once expired
        for (int k = 0; k < 20004; k++)
            cyc(1'b0, GAME, (k == 0) ? 8'd2 : 8'($urandom), 1'b0, (k > 20000),
                8'($urandom_range(1, 9)));
        repeat (2) cyc(1'b0, SCORE, 8'd0, 1'b0, 1'b0, 8'd0);

        // Random pause bursts and small random bonuses
        for (int k = 0; k < 12000 && !(k > 0 && m_mode == MExpired); k++) begin
            if ($urandom_range(0, 499) == 0) p = ~p;
            cyc(1'b0, GAME, (k == 0) ? 8'd1 : 8'($urandom), p, ($urandom_range(0, 1499) == 0),
                8'($urandom_range(0, 3)));
        end
        repeat (2) cyc(1'b0, MENU, 8'd0, 1'b0, 1'b0, 8'd0);

        // Bonus on the exact expiry cycle cancels expiry
        for (int k = 0; k < 19995; k++)
            cyc(1'b0, GAME, (k == 0) ? 8'd1 : 8'($urandom), 1'b0, (k == 10000), 8'd1);
        repeat (2) cyc(1'b0, SCORE, 8'd0, 1'b0, 1'b0, 8'd0);

        // Saturating adds, including one while paused
        for (int k = 0; k < 40; k++)
            cyc(1'b0, GAME, (k == 0) ? 8'd250 : 8'($urandom), (k >= 5 && k < 8),
                (k == 3 || k == 6 || k == 20),
                (k == 20) ? 8'd200 : ((k == 3) ? 8'd3 : 8'd10));
        repeat (2) cyc(1'b0, MENU, 8'd0, 1'b0, 1'b0, 8'd0);

        // Leave GAME on the expiry cycle, then a fresh round
        for (int k = 0; k <= 10000; k++)
            cyc(1'b0, (k == 10000) ? SCORE : GAME, (k == 0) ? 8'd1 : 8'($urandom),
                1'b0, 1'b0, 8'd0);
        repeat (2) cyc(1'b0, SCORE, 8'd0, 1'b0, 1'b0, 8'd0);
        for (int k = 0; k < 10004; k++)
            cyc(1'b0, GAME, (k == 0) ? 8'd1 : 8'($urandom), 1'b0, 1'b0, 8'd0);
        repeat (2) cyc(1'b0, SCORE, 8'd0, 1'b0, 1'b0, 8'd0);

        // Zero-length round, then reset in the middle of a run
        for (int k = 0; k < 5; k++)
            cyc(1'b0, GAME, 8'd0, 1'b0, (k == 2), 8'd5);
        repeat (2) cyc(1'b0, MENU, 8'd3, 1'b0, 1'b0, 8'd0);
        for (int k = 0; k < 300; k++)
            cyc((k >= 200 && k < 202), GAME, (k == 0) ? 8'd3 : 8'($urandom), 1'b0, 1'b0, 8'd0);
        repeat (3) cyc(1'b0, SCORE, 8'd0, 1'b0, 1'b0, 8'd0);

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected records left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
